// File: rtl/rggen_axi4lite_slice.sv
// rggen_axi4lite_slice: AXI4-Lite register slice with per-direction outstanding limiter.
// Latency: 0 (mode 0) or 1 (modes 1/2) cycle per channel; pending counts are registered.
// Backpressure: mode 1 has a combinational ready path; mode 2 presents a registered ready.
//   Slave awready/arready are also held low while the write/read count sits at MAX_OUTSTANDING.
// Ports: i_clk/i_rst (sync, active-high); i_s_*/o_s_* = upstream slave side (from master);
//   o_m_*/i_m_* = downstream master side (to register block); o_write_pending/o_read_pending.

// rggen_axi4lite_slice_ch: one valid/ready channel stage (bypass / forward / full skid).
// Latency: 0 for MODE 0, 1 for MODE 1 and 2.
// Backpressure: MODE 1 in_rdy depends combinationally on out_rdy; MODE 2 in_rdy is a flop.
module rggen_axi4lite_slice_ch #(
  parameter int MODE  = 2,
  parameter int WIDTH = 1
)(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_vld,
  output logic             o_in_rdy,
  input  logic [WIDTH-1:0] i_in_dat,
  output logic             o_out_vld,
  input  logic             i_out_rdy,
  output logic [WIDTH-1:0] o_out_dat
);
  if (MODE == 0) begin : g_bypass
    assign o_out_vld = i_in_vld;
    assign o_out_dat = i_in_dat;
    assign o_in_rdy  = i_out_rdy;
  end else if (MODE == 1) begin : g_fwd
    logic             r_vld;
    logic [WIDTH-1:0] r_dat;
    // Stage can take a beat when empty or when its current beat leaves this cycle.
    assign o_in_rdy  = !r_vld || i_out_rdy;
    assign o_out_vld = r_vld;
    assign o_out_dat = r_dat;
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_vld <= 1'b0;
        r_dat <= '0;
      end else if (o_in_rdy) begin
        r_vld <= i_in_vld;
        if (i_in_vld) r_dat <= i_in_dat;
      end
    end
  end else begin : g_skid
    logic             r_main_vld;
    logic             r_skid_vld;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             w_in_hs;
    logic             w_main_free;
    // Ready only reflects the skid flop, so upstream never sees a combinational path.
    assign o_in_rdy    = !r_skid_vld;
    assign w_in_hs     = i_in_vld && !r_skid_vld;
    assign w_main_free = !r_main_vld || i_out_rdy;
    assign o_out_vld   = r_main_vld;
    assign o_out_dat   = r_main;
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_main_vld <= 1'b0;
        r_skid_vld <= 1'b0;
        r_main     <= '0;
        r_skid     <= '0;
      end else if (w_main_free) begin
        // Skid holds the older beat, so it always refills main first (order kept).
        if (r_skid_vld) begin
          r_main     <= r_skid;
          r_main_vld <= 1'b1;
          r_skid_vld <= 1'b0;
        end else begin
          r_main_vld <= w_in_hs;
          if (w_in_hs) r_main <= i_in_dat;
        end
      end else if (w_in_hs) begin
        r_skid     <= i_in_dat;
        r_skid_vld <= 1'b1;
      end
    end
  end
endmodule

module rggen_axi4lite_slice #(
  parameter int ID_WIDTH        = 0,
  parameter int ADDRESS_WIDTH   = 16,
  parameter int BUS_WIDTH       = 32,
  parameter int AW_MODE         = 2,
  parameter int W_MODE          = 2,
  parameter int B_MODE          = 2,
  parameter int AR_MODE         = 2,
  parameter int R_MODE          = 2,
  parameter int MAX_OUTSTANDING = 4,
  localparam int IW = (ID_WIDTH > 0) ? ID_WIDTH : 1,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1)
)(
  input  logic                     i_clk,
  input  logic                     i_rst,
  // upstream slave side
  input  logic                     i_s_awvalid,
  output logic                     o_s_awready,
  input  logic [IW-1:0]            i_s_awid,
  input  logic [ADDRESS_WIDTH-1:0] i_s_awaddr,
  input  logic [2:0]               i_s_awprot,
  input  logic                     i_s_wvalid,
  output logic                     o_s_wready,
  input  logic [BUS_WIDTH-1:0]     i_s_wdata,
  input  logic [BUS_WIDTH/8-1:0]   i_s_wstrb,
  output logic                     o_s_bvalid,
  input  logic                     i_s_bready,
  output logic [IW-1:0]            o_s_bid,
  output logic [1:0]               o_s_bresp,
  input  logic                     i_s_arvalid,
  output logic                     o_s_arready,
  input  logic [IW-1:0]            i_s_arid,
  input  logic [ADDRESS_WIDTH-1:0] i_s_araddr,
  input  logic [2:0]               i_s_arprot,
  output logic                     o_s_rvalid,
  input  logic                     i_s_rready,
  output logic [IW-1:0]            o_s_rid,
  output logic [BUS_WIDTH-1:0]     o_s_rdata,
  output logic [1:0]               o_s_rresp,
  // downstream master side
  output logic                     o_m_awvalid,
  input  logic                     i_m_awready,
  output logic [IW-1:0]            o_m_awid,
  output logic [ADDRESS_WIDTH-1:0] o_m_awaddr,
  output logic [2:0]               o_m_awprot,
  output logic                     o_m_wvalid,
  input  logic                     i_m_wready,
  output logic [BUS_WIDTH-1:0]     o_m_wdata,
  output logic [BUS_WIDTH/8-1:0]   o_m_wstrb,
  input  logic                     i_m_bvalid,
  output logic                     o_m_bready,
  input  logic [IW-1:0]            i_m_bid,
  input  logic [1:0]               i_m_bresp,
  output logic                     o_m_arvalid,
  input  logic                     i_m_arready,
  output logic [IW-1:0]            o_m_arid,
  output logic [ADDRESS_WIDTH-1:0] o_m_araddr,
  output logic [2:0]               o_m_arprot,
  input  logic                     i_m_rvalid,
  output logic                     o_m_rready,
  input  logic [IW-1:0]            i_m_rid,
  input  logic [BUS_WIDTH-1:0]     i_m_rdata,
  input  logic [1:0]               i_m_rresp,
  // status
  output logic [CW-1:0]            o_write_pending,
  output logic [CW-1:0]            o_read_pending
);
  localparam int SW  = BUS_WIDTH / 8;
  localparam int AXW = IW + ADDRESS_WIDTH + 3;
  localparam int WW  = BUS_WIDTH + SW;
  localparam int BW  = IW + 2;
  localparam int RW  = IW + BUS_WIDTH + 2;

  // With no ID bits the ID fields are a dummy bit tied to zero in both directions.
  logic [IW-1:0] w_awid, w_arid, w_bid, w_rid;
  assign w_awid = (ID_WIDTH == 0) ? '0 : i_s_awid;
  assign w_arid = (ID_WIDTH == 0) ? '0 : i_s_arid;
  assign w_bid  = (ID_WIDTH == 0) ? '0 : i_m_bid;
  assign w_rid  = (ID_WIDTH == 0) ? '0 : i_m_rid;

  logic [CW-1:0] r_wcnt, r_rcnt;
  logic          w_wfull, w_rfull;
  logic          w_aw_in_rdy, w_ar_in_rdy;
  logic          w_aw_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic [AXW-1:0] w_aw_out, w_ar_out;
  logic [WW-1:0]  w_w_out;
  logic [BW-1:0]  w_b_out;
  logic [RW-1:0]  w_r_out;

  assign w_wfull = (r_wcnt == CW'(MAX_OUTSTANDING));
  assign w_rfull = (r_rcnt == CW'(MAX_OUTSTANDING));

  // The limiter masks valid into the slice and ready out of it, so slice state is untouched.
  assign o_s_awready = w_aw_in_rdy && !w_wfull;
  assign o_s_arready = w_ar_in_rdy && !w_rfull;

  assign w_aw_hs = i_s_awvalid && o_s_awready;
  assign w_b_hs  = o_s_bvalid && i_s_bready;
  assign w_ar_hs = i_s_arvalid && o_s_arready;
  assign w_r_hs  = o_s_rvalid && i_s_rready;

  rggen_axi4lite_slice_ch #(.MODE(AW_MODE), .WIDTH(AXW)) u_aw (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_in_vld(i_s_awvalid && !w_wfull), .o_in_rdy(w_aw_in_rdy),
    .i_in_dat({w_awid, i_s_awaddr, i_s_awprot}),
    .o_out_vld(o_m_awvalid), .i_out_rdy(i_m_awready), .o_out_dat(w_aw_out)
  );
  assign {o_m_awid, o_m_awaddr, o_m_awprot} = w_aw_out;

  rggen_axi4lite_slice_ch #(.MODE(W_MODE), .WIDTH(WW)) u_w (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_in_vld(i_s_wvalid), .o_in_rdy(o_s_wready),
    .i_in_dat({i_s_wdata, i_s_wstrb}),
    .o_out_vld(o_m_wvalid), .i_out_rdy(i_m_wready), .o_out_dat(w_w_out)
  );
  assign {o_m_wdata, o_m_wstrb} = w_w_out;

  rggen_axi4lite_slice_ch #(.MODE(B_MODE), .WIDTH(BW)) u_b (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_in_vld(i_m_bvalid), .o_in_rdy(o_m_bready),
    .i_in_dat({w_bid, i_m_bresp}),
    .o_out_vld(o_s_bvalid), .i_out_rdy(i_s_bready), .o_out_dat(w_b_out)
  );
  assign {o_s_bid, o_s_bresp} = w_b_out;

  rggen_axi4lite_slice_ch #(.MODE(AR_MODE), .WIDTH(AXW)) u_ar (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_in_vld(i_s_arvalid && !w_rfull), .o_in_rdy(w_ar_in_rdy),
    .i_in_dat({w_arid, i_s_araddr, i_s_arprot}),
    .o_out_vld(o_m_arvalid), .i_out_rdy(i_m_arready), .o_out_dat(w_ar_out)
  );
  assign {o_m_arid, o_m_araddr, o_m_arprot} = w_ar_out;

  rggen_axi4lite_slice_ch #(.MODE(R_MODE), .WIDTH(RW)) u_r (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_in_vld(i_m_rvalid), .o_in_rdy(o_m_rready),
    .i_in_dat({w_rid, i_m_rdata, i_m_rresp}),
    .o_out_vld(o_s_rvalid), .i_out_rdy(i_s_rready), .o_out_dat(w_r_out)
  );
  assign {o_s_rid, o_s_rdata, o_s_rresp} = w_r_out;

  // Request and response in the same cycle cancel; a response at zero is held, not wrapped.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wcnt <= '0;
      r_rcnt <= '0;
    end else begin
      if (w_aw_hs && !w_b_hs) r_wcnt <= r_wcnt + CW'(1);
      else if (!w_aw_hs && w_b_hs && (r_wcnt != '0)) r_wcnt <= r_wcnt - CW'(1);
      if (w_ar_hs && !w_r_hs) r_rcnt <= r_rcnt + CW'(1);
      else if (!w_ar_hs && w_r_hs && (r_rcnt != '0)) r_rcnt <= r_rcnt - CW'(1);
    end
  end

  assign o_write_pending = r_wcnt;
  assign o_read_pending  = r_rcnt;

  // A response with nothing outstanding means the downstream block misbehaved.
  a_no_b_at_zero: assert property (@(posedge i_clk) disable iff (i_rst)
    !(w_b_hs && (r_wcnt == '0)));
  a_no_r_at_zero: assert property (@(posedge i_clk) disable iff (i_rst)
    !(w_r_hs && (r_rcnt == '0)));
endmodule

// File: tb/tb_rggen_axi4lite_slice.sv
module tb_rggen_axi4lite_slice;
  logic        clk = 1'b0;
  logic        rst;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  // shared stimulus (drives both instances)
  logic        i_s_awvalid, i_s_wvalid, i_s_bready, i_s_arvalid, i_s_rready;
  logic [0:0]  i_s_awid, i_s_arid, i_m_bid, i_m_rid;
  logic [15:0] i_s_awaddr, i_s_araddr;
  logic [2:0]  i_s_awprot, i_s_arprot;
  logic [31:0] i_s_wdata, i_m_rdata;
  logic [3:0]  i_s_wstrb;
  logic        i_m_awready, i_m_wready, i_m_bvalid, i_m_arready, i_m_rvalid;
  logic [1:0]  i_m_bresp, i_m_rresp;

  // outputs of u_dut (MAX_OUTSTANDING=2)
  logic        o_s_awready, o_s_wready, o_s_bvalid, o_s_arready, o_s_rvalid;
  logic [0:0]  o_s_bid, o_s_rid, o_m_awid, o_m_arid;
  logic [1:0]  o_s_bresp, o_s_rresp;
  logic [31:0] o_s_rdata, o_m_wdata;
  logic        o_m_awvalid, o_m_wvalid, o_m_bready, o_m_arvalid, o_m_rready;
  logic [15:0] o_m_awaddr, o_m_araddr;
  logic [2:0]  o_m_awprot, o_m_arprot;
  logic [3:0]  o_m_wstrb;
  logic [1:0]  o_write_pending, o_read_pending;

  // outputs of u_big (MAX_OUTSTANDING=8)
  logic        x_s_awready, x_s_wready, x_s_bvalid, x_s_arready, x_s_rvalid;
  logic [0:0]  x_s_bid, x_s_rid, x_m_awid, x_m_arid;
  logic [1:0]  x_s_bresp, x_s_rresp;
  logic [31:0] x_s_rdata, x_m_wdata;
  logic        x_m_awvalid, x_m_wvalid, x_m_bready, x_m_arvalid, x_m_rready;
  logic [15:0] x_m_awaddr, x_m_araddr;
  logic [2:0]  x_m_awprot, x_m_arprot;
  logic [3:0]  x_m_wstrb;
  logic [3:0]  x_write_pending, x_read_pending;

  rggen_axi4lite_slice #(.MAX_OUTSTANDING(2)) u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_s_awvalid(i_s_awvalid), .o_s_awready(o_s_awready), .i_s_awid(i_s_awid),
    .i_s_awaddr(i_s_awaddr), .i_s_awprot(i_s_awprot),
    .i_s_wvalid(i_s_wvalid), .o_s_wready(o_s_wready), .i_s_wdata(i_s_wdata), .i_s_wstrb(i_s_wstrb),
    .o_s_bvalid(o_s_bvalid), .i_s_bready(i_s_bready), .o_s_bid(o_s_bid), .o_s_bresp(o_s_bresp),
    .i_s_arvalid(i_s_arvalid), .o_s_arready(o_s_arready), .i_s_arid(i_s_arid),
    .i_s_araddr(i_s_araddr), .i_s_arprot(i_s_arprot),
    .o_s_rvalid(o_s_rvalid), .i_s_rready(i_s_rready), .o_s_rid(o_s_rid),
    .o_s_rdata(o_s_rdata), .o_s_rresp(o_s_rresp),
    .o_m_awvalid(o_m_awvalid), .i_m_awready(i_m_awready), .o_m_awid(o_m_awid),
    .o_m_awaddr(o_m_awaddr), .o_m_awprot(o_m_awprot),
    .o_m_wvalid(o_m_wvalid), .i_m_wready(i_m_wready), .o_m_wdata(o_m_wdata), .o_m_wstrb(o_m_wstrb),
    .i_m_bvalid(i_m_bvalid), .o_m_bready(o_m_bready), .i_m_bid(i_m_bid), .i_m_bresp(i_m_bresp),
    .o_m_arvalid(o_m_arvalid), .i_m_arready(i_m_arready), .o_m_arid(o_m_arid),
    .o_m_araddr(o_m_araddr), .o_m_arprot(o_m_arprot),
    .i_m_rvalid(i_m_rvalid), .o_m_rready(o_m_rready), .i_m_rid(i_m_rid),
    .i_m_rdata(i_m_rdata), .i_m_rresp(i_m_rresp),
    .o_write_pending(o_write_pending), .o_read_pending(o_read_pending)
  );

  rggen_axi4lite_slice #(.MAX_OUTSTANDING(8)) u_big (
    .i_clk(clk), .i_rst(rst),
    .i_s_awvalid(i_s_awvalid), .o_s_awready(x_s_awready), .i_s_awid(i_s_awid),
    .i_s_awaddr(i_s_awaddr), .i_s_awprot(i_s_awprot),
    .i_s_wvalid(i_s_wvalid), .o_s_wready(x_s_wready), .i_s_wdata(i_s_wdata), .i_s_wstrb(i_s_wstrb),
    .o_s_bvalid(x_s_bvalid), .i_s_bready(i_s_bready), .o_s_bid(x_s_bid), .o_s_bresp(x_s_bresp),
    .i_s_arvalid(i_s_arvalid), .o_s_arready(x_s_arready), .i_s_arid(i_s_arid),
    .i_s_araddr(i_s_araddr), .i_s_arprot(i_s_arprot),
    .o_s_rvalid(x_s_rvalid), .i_s_rready(i_s_rready), .o_s_rid(x_s_rid),
    .o_s_rdata(x_s_rdata), .o_s_rresp(x_s_rresp),
    .o_m_awvalid(x_m_awvalid), .i_m_awready(i_m_awready), .o_m_awid(x_m_awid),
    .o_m_awaddr(x_m_awaddr), .o_m_awprot(x_m_awprot),
    .o_m_wvalid(x_m_wvalid), .i_m_wready(i_m_wready), .o_m_wdata(x_m_wdata), .o_m_wstrb(x_m_wstrb),
    .i_m_bvalid(i_m_bvalid), .o_m_bready(x_m_bready), .i_m_bid(i_m_bid), .i_m_bresp(i_m_bresp),
    .o_m_arvalid(x_m_arvalid), .i_m_arready(i_m_arready), .o_m_arid(x_m_arid),
    .o_m_araddr(x_m_araddr), .o_m_arprot(x_m_arprot),
    .i_m_rvalid(i_m_rvalid), .o_m_rready(x_m_rready), .i_m_rid(i_m_rid),
    .i_m_rdata(i_m_rdata), .i_m_rresp(i_m_rresp),
    .o_write_pending(x_write_pending), .o_read_pending(x_read_pending)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    i_s_awvalid = 0; i_s_awid = 1'b1; i_s_awaddr = '0; i_s_awprot = '0;
    i_s_wvalid = 0; i_s_wdata = '0; i_s_wstrb = 4'hF; i_s_bready = 1;
    i_s_arvalid = 0; i_s_arid = 1'b1; i_s_araddr = '0; i_s_arprot = '0; i_s_rready = 1;
    i_m_awready = 1; i_m_wready = 1; i_m_arready = 1;
    i_m_bvalid = 0; i_m_bid = 1'b0; i_m_bresp = '0;
    i_m_rvalid = 0; i_m_rid = 1'b0; i_m_rdata = '0; i_m_rresp = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1;
    repeat (2) step();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_chk++; if (o_s_awready !== 1'b1) $display("FAIL reset_awready got %b want 1", o_s_awready); else n_pass++;
    n_chk++; if (o_s_wready !== 1'b1) $display("FAIL reset_wready got %b want 1", o_s_wready); else n_pass++;
    n_chk++; if (o_s_arready !== 1'b1) $display("FAIL reset_arready got %b want 1", o_s_arready); else n_pass++;
    n_chk++; if ({o_m_awvalid, o_m_wvalid, o_m_arvalid, o_s_bvalid, o_s_rvalid} !== 5'b0)
      $display("FAIL reset_valids got %b want 00000", {o_m_awvalid, o_m_wvalid, o_m_arvalid, o_s_bvalid, o_s_rvalid}); else n_pass++;
    n_chk++; if ({o_write_pending, o_read_pending} !== 4'b0)
      $display("FAIL reset_pending got w%0d r%0d want 0 0", o_write_pending, o_read_pending); else n_pass++;
    step();
  endtask

  task automatic test_throughput();
    logic [15:0] addr_tab [8] = '{16'h00, 16'h04, 16'h08, 16'h0C, 16'h10, 16'h14, 16'h18, 16'h1C};
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      if (c < 8) begin
        i_s_arvalid = 1; i_s_araddr = addr_tab[c]; i_s_arprot = 3'(c);
      end else begin
        i_s_arvalid = 0;
      end
      @(negedge clk);
      if (c < 8) begin
        n_chk++; if (x_s_arready !== 1'b1) $display("FAIL tput_arready[%0d] got %b want 1", c, x_s_arready); else n_pass++;
      end
      if (c >= 1) begin
        n_chk++;
        if (x_m_arvalid !== 1'b1 || x_m_araddr !== addr_tab[c-1] || x_m_arprot !== 3'(c-1))
          $display("FAIL tput_ar[%0d] got v%b a%h p%0d want v1 a%h p%0d", c, x_m_arvalid, x_m_araddr, x_m_arprot, addr_tab[c-1], c-1);
        else n_pass++;
      end
      step();
    end
    @(negedge clk);
    n_chk++; if (x_m_arvalid !== 1'b0) $display("FAIL tput_tail_valid got %b want 0", x_m_arvalid); else n_pass++;
    n_chk++; if (x_read_pending !== 4'd8) $display("FAIL tput_pending got %0d want 8", x_read_pending); else n_pass++;
    step();
  endtask

  task automatic test_skid();
    do_reset();
    i_m_awready = 0;
    i_s_awvalid = 1; i_s_awaddr = 16'h0010; i_s_awprot = 3'd1;
    @(negedge clk);
    n_chk++; if (o_s_awready !== 1'b1) $display("FAIL skid_acc0 got %b want 1", o_s_awready); else n_pass++;
    step();
    i_s_awaddr = 16'h0014; i_s_awprot = 3'd2;
    @(negedge clk);
    n_chk++; if (o_s_awready !== 1'b1) $display("FAIL skid_acc1 got %b want 1", o_s_awready); else n_pass++;
    step();
    i_s_awvalid = 0;
    @(negedge clk);
    n_chk++; if (x_s_awready !== 1'b0) $display("FAIL skid_full_rdy got %b want 0", x_s_awready); else n_pass++;
    n_chk++; if (o_s_awready !== 1'b0) $display("FAIL skid_slave_rdy got %b want 0", o_s_awready); else n_pass++;
    n_chk++; if (o_m_awvalid !== 1'b1 || o_m_awaddr !== 16'h0010)
      $display("FAIL skid_stall_hold got v%b a%h want v1 a0010", o_m_awvalid, o_m_awaddr); else n_pass++;
    step();
    i_m_awready = 1;
    @(negedge clk);
    n_chk++; if (o_m_awvalid !== 1'b1 || o_m_awaddr !== 16'h0010 || o_m_awprot !== 3'd1)
      $display("FAIL skid_out0 got v%b a%h p%0d want v1 a0010 p1", o_m_awvalid, o_m_awaddr, o_m_awprot); else n_pass++;
    step();
    @(negedge clk);
    n_chk++; if (o_m_awvalid !== 1'b1 || o_m_awaddr !== 16'h0014 || o_m_awprot !== 3'd2)
      $display("FAIL skid_out1 got v%b a%h p%0d want v1 a0014 p2", o_m_awvalid, o_m_awaddr, o_m_awprot); else n_pass++;
    step();
    @(negedge clk);
    n_chk++; if (o_m_awvalid !== 1'b0) $display("FAIL skid_no_dup got %b want 0", o_m_awvalid); else n_pass++;
    step();
  endtask

  task automatic test_limit();
    do_reset();
    i_s_awvalid = 1; i_s_awaddr = 16'h0000; i_s_wvalid = 1; i_s_wdata = 32'hA0;
    @(negedge clk);
    n_chk++; if (o_s_awready !== 1'b1) $display("FAIL lim_aw0 got %b want 1", o_s_awready); else n_pass++;
    step();
    i_s_awaddr = 16'h0004; i_s_wdata = 32'hA1;
    @(negedge clk);
    n_chk++; if (o_s_awready !== 1'b1) $display("FAIL lim_aw1 got %b want 1", o_s_awready); else n_pass++;
    step();
    i_s_awaddr = 16'h0008; i_s_wdata = 32'hA2;
    @(negedge clk);
    n_chk++; if (o_s_awready !== 1'b0) $display("FAIL lim_blocked got %b want 0", o_s_awready); else n_pass++;
    n_chk++; if (o_write_pending !== 2'd2) $display("FAIL lim_pend2 got %0d want 2", o_write_pending); else n_pass++;
    n_chk++; if (o_s_wready !== 1'b1) $display("FAIL lim_w_ungated got %b want 1", o_s_wready); else n_pass++;
    step();
    i_s_wvalid = 0; i_m_bvalid = 1; i_m_bresp = 2'b10; i_m_bid = 1'b1;
    @(negedge clk);
    n_chk++; if (o_s_awready !== 1'b0) $display("FAIL lim_still_blocked got %b want 0", o_s_awready); else n_pass++;
    step();
    i_m_bvalid = 0;
    @(negedge clk);
    n_chk++; if (o_s_bvalid !== 1'b1 || o_s_bresp !== 2'b10)
      $display("FAIL lim_b got v%b r%b want v1 r10", o_s_bvalid, o_s_bresp); else n_pass++;
    n_chk++; if (o_s_bid !== 1'b0) $display("FAIL lim_bid_zero got %b want 0", o_s_bid); else n_pass++;
    n_chk++; if (o_write_pending !== 2'd2) $display("FAIL lim_pend_preb got %0d want 2", o_write_pending); else n_pass++;
    step();
    @(negedge clk);
    n_chk++; if (o_write_pending !== 2'd1) $display("FAIL lim_pend1 got %0d want 1", o_write_pending); else n_pass++;
    n_chk++; if (o_s_awready !== 1'b1) $display("FAIL lim_reopen got %b want 1", o_s_awready); else n_pass++;
    step();
    i_s_awvalid = 0;
    @(negedge clk);
    n_chk++; if (o_write_pending !== 2'd2) $display("FAIL lim_pend_third got %0d want 2", o_write_pending); else n_pass++;
    n_chk++; if (o_m_awvalid !== 1'b1 || o_m_awaddr !== 16'h0008)
      $display("FAIL lim_third_out got v%b a%h want v1 a0008", o_m_awvalid, o_m_awaddr); else n_pass++;
    step();
  endtask

  task automatic test_simultaneous();
    do_reset();
    i_s_arvalid = 1; i_s_araddr = 16'h0020;
    step();
    i_s_arvalid = 0; i_m_rvalid = 1; i_m_rdata = 32'h0000_1234; i_m_rresp = 2'b01;
    @(negedge clk);
    n_chk++; if (o_read_pending !== 2'd1) $display("FAIL sim_pend_pre got %0d want 1", o_read_pending); else n_pass++;
    step();
    i_m_rvalid = 0; i_s_arvalid = 1; i_s_araddr = 16'h0024;
    @(negedge clk);
    n_chk++; if (o_s_rvalid !== 1'b1 || o_s_rdata !== 32'h0000_1234 || o_s_rresp !== 2'b01)
      $display("FAIL sim_r got v%b d%h r%b want v1 d00001234 r01", o_s_rvalid, o_s_rdata, o_s_rresp); else n_pass++;
    n_chk++; if (o_s_arready !== 1'b1) $display("FAIL sim_arready got %b want 1", o_s_arready); else n_pass++;
    step();
    i_s_arvalid = 0;
    @(negedge clk);
    n_chk++; if (o_read_pending !== 2'd1) $display("FAIL sim_pend_post got %0d want 1", o_read_pending); else n_pass++;
    n_chk++; if (o_m_arvalid !== 1'b1 || o_m_araddr !== 16'h0024)
      $display("FAIL sim_ar2 got v%b a%h want v1 a0024", o_m_arvalid, o_m_araddr); else n_pass++;
    step();
  endtask

  task automatic test_midop_reset();
    do_reset();
    i_m_wready = 0;
    i_s_awvalid = 1; i_s_awaddr = 16'h0040;
    i_s_wvalid = 1; i_s_wdata = 32'h1111_1111;
    step();
    i_s_awvalid = 0; i_s_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_chk++; if (o_s_wready !== 1'b1) $display("FAIL mid_w1_acc got %b want 1", o_s_wready); else n_pass++;
    step();
    i_s_wvalid = 0; rst = 1;
    @(negedge clk);
    n_chk++; if (o_s_wready !== 1'b0) $display("FAIL mid_skid_full got %b want 0", o_s_wready); else n_pass++;
    n_chk++; if (o_m_wdata !== 32'h1111_1111) $display("FAIL mid_main got %h want 11111111", o_m_wdata); else n_pass++;
    n_chk++; if (o_write_pending !== 2'd1) $display("FAIL mid_pend_pre got %0d want 1", o_write_pending); else n_pass++;
    step();
    rst = 0; i_m_wready = 1;
    @(negedge clk);
    n_chk++; if (o_m_wvalid !== 1'b0) $display("FAIL mid_wvalid got %b want 0", o_m_wvalid); else n_pass++;
    n_chk++; if (o_s_wready !== 1'b1) $display("FAIL mid_wready got %b want 1", o_s_wready); else n_pass++;
    n_chk++; if (o_write_pending !== 2'd0) $display("FAIL mid_pend got %0d want 0", o_write_pending); else n_pass++;
    step();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_chk++; if (o_m_wvalid !== 1'b0) $display("FAIL mid_no_replay[%0d] got %b want 0", c, o_m_wvalid); else n_pass++;
      step();
    end
  endtask

  initial begin
    rst = 1;
    drive_idle();
    test_reset();
    test_throughput();
    test_skid();
    test_limit();
    test_simultaneous();
    test_midop_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
